// File: rtl/comparador_serial_der_izq.sv
// Bit-serial LSB-first magnitude comparator with start/valid/busy/done handshake.
// Define COMPARADOR_SIGNED_EN to compare two's-complement operands.
module comparador_serial_der_izq #(
  parameter int N = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic bit_valid,
  input  logic A_i,
  input  logic B_i,
  output logic busy,
  output logic done,
  output logic P,
  output logic Q,
  output logic igual
);

  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          last;
  logic          gt;
  logic          lt;

  assign last = (cnt == CW'(N - 1));

  // gt/lt: this bit alone says A>B / A<B
  always_comb begin
    gt = A_i & ~B_i;
    lt = ~A_i & B_i;
`ifdef COMPARADOR_SIGNED_EN
    // the sign bit weighs negatively, so its verdict flips
    if (last) begin
      gt = ~A_i & B_i;
      lt = A_i & ~B_i;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      P     <= 1'b0;
      Q     <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            P     <= 1'b0;
            Q     <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (bit_valid) begin
            cnt <= cnt + 1'b1;
            if (gt) begin
              P <= 1'b1;
              Q <= 1'b0;
            end else if (lt) begin
              P <= 1'b0;
              Q <= 1'b1;
            end
            if (last) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign igual = ~P & ~Q;

endmodule

// File: tb/tb_comparador_serial_der_izq.sv
// Self-checking bench: N=4 directed cases and N=8 random regression
// against an arithmetic compare model, checked every cycle.
module tb_comparador_serial_der_izq;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] st = 2'b00;
  logic       bv = 1'b0;
  logic       ai = 1'b0;
  logic       bi = 1'b0;
  logic [1:0] bsy, dn, pp, qq, ig;

  logic [1:0] e_busy = 2'b00;
  logic [1:0] e_done = 2'b00;
  logic [1:0] e_p = 2'b00;
  logic [1:0] e_q = 2'b00;
  logic [1:0] e_chk = 2'b11;

  int nvec = 0;
  int nfail = 0;
  int stl [16];

  always #5 clk = ~clk;

  comparador_serial_der_izq #(.N(4)) dut4 (
    .clk(clk), .reset(reset), .start(st[0]),
    .bit_valid(bv), .A_i(ai), .B_i(bi),
    .busy(bsy[0]), .done(dn[0]), .P(pp[0]),
    .Q(qq[0]), .igual(ig[0])
  );

  comparador_serial_der_izq #(.N(8)) dut8 (
    .clk(clk), .reset(reset), .start(st[1]),
    .bit_valid(bv), .A_i(ai), .B_i(bi),
    .busy(bsy[1]), .done(dn[1]), .P(pp[1]),
    .Q(qq[1]), .igual(ig[1])
  );

  function automatic logic [1:0] model(
    input int n, input logic [15:0] a, input logic [15:0] b
  );
    logic [15:0] m;
    int x, y;
    m = 16'((1 << n) - 1);
    x = int'(a & m);
    y = int'(b & m);
`ifdef COMPARADOR_SIGNED_EN
    if (x >= (1 << (n - 1))) x = x - (1 << n);
    if (y >= (1 << (n - 1))) y = y - (1 << n);
`endif
    if (x > y) return 2'b10;
    if (x < y) return 2'b01;
    return 2'b00;
  endfunction

  task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s t=%0t got %b want %b", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("busy%0d", d), {1'b0, bsy[d]}, {1'b0, e_busy[d]});
      chk($sformatf("done%0d", d), {1'b0, dn[d]}, {1'b0, e_done[d]});
      chk($sformatf("pq_not11_%0d", d), {1'b0, pp[d] & qq[d]}, 2'b00);
      if (e_chk[d]) begin
        chk($sformatf("pq%0d", d), {pp[d], qq[d]}, {e_p[d], e_q[d]});
        chk($sformatf("igual%0d", d), {1'b0, ig[d]},
            {1'b0, ~e_p[d] & ~e_q[d]});
      end
    end
  end

  task automatic clr_stl();
    for (int i = 0; i < 16; i++) stl[i] = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // drive one comparison on DUT sel; expectations are derived from
  // the schedule: busy after start edge, done after the N-th bit edge
  task automatic run(input int sel, input int n, input logic [15:0] a,
                     input logic [15:0] b, input bit spur, input int abort_at);
    logic [1:0] pq;
    pq = model(n, a, b);
    st[sel] = 1'b1;
    bv = 1'($urandom);
    ai = 1'($urandom);
    bi = 1'($urandom);
    step();
    st[sel] = 1'b0;
    e_busy[sel] = 1'b1;
    e_done[sel] = 1'b0;
    e_chk[sel] = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i == abort_at) begin
        reset = 1'b1;
        bv = 1'b0;
        #1;
        chk("abort_busy", {1'b0, bsy[sel]}, 2'b00);
        chk("abort_pq", {pp[sel], qq[sel]}, 2'b00);
        chk("abort_igual", {1'b0, ig[sel]}, 2'b01);
        e_busy = 2'b00;
        e_done = 2'b00;
        e_p = 2'b00;
        e_q = 2'b00;
        e_chk = 2'b11;
        #5;
        reset = 1'b0;
        step();
        return;
      end
      for (int s = 0; s < stl[i]; s++) begin
        bv = 1'b0;
        ai = 1'($urandom);
        bi = 1'($urandom);
        if (spur && s == 0) st[sel] = 1'b1;
        step();
        st[sel] = 1'b0;
      end
      bv = 1'b1;
      ai = a[i];
      bi = b[i];
      if (spur && i == 1) st[sel] = 1'b1;
      step();
      st[sel] = 1'b0;
    end
    e_busy[sel] = 1'b0;
    e_done[sel] = 1'b1;
    e_p[sel] = pq[1];
    e_q[sel] = pq[0];
    e_chk[sel] = 1'b1;
    bv = 1'($urandom);
    ai = 1'($urandom);
    bi = 1'($urandom);
    if (spur) st[sel] = 1'b1;
    step();
    st[sel] = 1'b0;
    e_done[sel] = 1'b0;
    bv = 1'b0;
  endtask

  initial begin
    logic [15:0] a, b;
    clr_stl();
    chk("model_gt", model(4, 16'b1010, 16'b1001), 2'b10);
    chk("model_eq", model(4, 16'b0110, 16'b0110), 2'b00);
    chk("model_lt", model(4, 16'b0011, 16'b0101), 2'b01);
`ifdef COMPARADOR_SIGNED_EN
    chk("model_sgn", model(4, 16'b1000, 16'b0111), 2'b01);
`else
    chk("model_uns", model(4, 16'b1000, 16'b0111), 2'b10);
`endif
    #1;
    chk("rst_igual", {1'b0, ig[0]}, 2'b01);
    #14;
    reset = 1'b0;
    step();

    run(0, 4, 16'b1010, 16'b1001, 1'b0, -1);
    run(0, 4, 16'b0110, 16'b0110, 1'b0, -1);
    run(0, 4, 16'b0011, 16'b0101, 1'b0, -1);
    stl[2] = 3;
    run(0, 4, 16'b1010, 16'b1001, 1'b1, -1);
    clr_stl();
    run(0, 4, 16'b1000, 16'b0111, 1'b0, -1);
    run(0, 4, 16'b1111, 16'b0000, 1'b1, 2);
    run(0, 4, 16'b0001, 16'b0000, 1'b0, -1);
    run(1, 8, 16'h80, 16'h7f, 1'b0, -1);

    for (int k = 0; k < 1000; k++) begin
      a = 16'($urandom_range(0, 255));
      case ($urandom_range(0, 3))
        0: b = a;
        1: b = a ^ (16'd1 << $urandom_range(0, 7));
        default: b = 16'($urandom_range(0, 255));
      endcase
      for (int i = 0; i < 8; i++)
        stl[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      run(1, 8, a, b, 1'($urandom), -1);
      for (int g = int'($urandom_range(0, 2)); g > 0; g--) begin
        bv = 1'($urandom);
        step();
      end
      bv = 1'b0;
    end
    clr_stl();
    step();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
